rv32i_pipe_param: RTL and testbench
===================================

Name: rv32i_pipe_param

Overview:
Parametrised successor to the team's 5-stage in-order pipeline (IF, ID, EX, MEM, WB). Uses the same 6-bit-opcode custom ISA and adds:
- asynchronous reset
- configurable data width and memory sizes
- data forwarding and a load-use interlock
- branch flush
- BNE/AND/OR
- HALT
- register-zero semantics

Instruction memory is external (combinational read); data memory and register file are internal.

Parameters:
XLEN, 32, datapath/register width (>=16)
NREG, 32, architectural registers (power of 2, <=32); index = low log2(NREG) bits of the field
IMEM_AW, 10, instruction address width (word-addressed PC)
DMEM_DEPTH, 1024, data memory words; address = ALU result modulo DMEM_DEPTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  IMEM_AW  fetch address (= pc)
imem_data  input  32  instruction at imem_addr, same cycle
pc  output  IMEM_AW  current fetch PC
wb_out  output  XLEN  value written to the register file in WB
wb_valid  output  1  one-cycle pulse when wb_out carries a register write
halted  output  1  sticky; HALT has retired

Behaviour:
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to XLEN.
- Opcodes: ADD0, SUB1, MUL2 (low XLEN bits), DIV3 (unsigned; divisor 0 gives all-ones), ADDI4, SUBI5, LOAD6, STORE7, BEQ8, AND9, OR10, BNE11, HALT63. Any other opcode is a NOP.
- Destinations: rd for R-type; rt for ADDI/SUBI/LOAD. Arithmetic wraps modulo 2^XLEN.
- Reset (async): pc=0; all stage valid bits=0 (bubbles); all registers=0; wb_out=0; wb_valid=0; halted=0. DMEM is not reset. Reset mid-run discards all in-flight instructions.
- Register 0 reads as 0. Writes to register 0 are suppressed, and wb_valid stays 0 for them.
- Register file is write-through: a same-cycle WB write is visible to ID.
- WB writes the current MEM/WB result, not the previous wb_out.
- Latency: an instruction fetched on edge N asserts wb_valid after edge N+4. Throughput is 1 per cycle absent hazards.
- Forwarding (FORWARD_EN): EX operands take EX/MEM ALU result, then MEM/WB result, then the register value, with priority in that order.
- STORE data is also forwarded.
- Load-use: a consumer directly after a LOAD stalls 1 cycle. IF/ID and pc are held and a bubble is inserted into EX.
- Branches: BEQ/BNE resolve in EX; target = branch pc+1+imm (wraps at 2^IMEM_AW).
- Taken branch: pc loads the target on the next edge; IF/ID and ID/EX are flushed (2 bubbles). Not-taken: no penalty.
- A stall and a taken branch in the same cycle: the flush wins.
- HALT: when decoded in ID, pc freezes and bubbles are fed in behind it. Older instructions drain. When HALT reaches WB, halted=1 and stays set until rst.
- A HALT squashed by a taken branch has no effect.

Optional Feature:
Macro RV_PIPE_FORWARD_EN.
- Defined: forwarding network as above; only the load-use case stalls.
- Undefined: no forwarding. ID stalls while any valid instruction in EX or MEM targets a source register of the ID instruction (register 0 excluded). The write-through register file covers the WB case. This costs up to 2 stall cycles; results are identical.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 -> wb_out 5, 7, 12 on consecutive cycles with FORWARD_EN; 2-cycle gap before 12 without.
- Continue: STORE r3,4(r0); LOAD r4,4(r0); ADD r5,r4,r4 -> exactly one bubble; wb_out 12 then 24; DMEM[4]=12.
- BEQ r1,r1,+2 followed by ADDI r6,r0,1 and ADDI r7,r0,2 -> no wb_valid from either; pc = branch pc+3. BNE r1,r1 -> not taken, both retire.
- DIV r8,r1,r0 -> wb_out 0xFFFFFFFF. ADDI r0,r0,9 -> no wb_valid; a later ADD r9,r0,r0 gives 0.
- HALT after 2 ADDIs -> both retire, then halted=1 and pc constant for 20 cycles. Asserting rst mid-stream: outputs 0 immediately (async); the first wb_valid comes 5 edges after release.
- XLEN=16: ADDI r1,r0,0x7FFF; ADDI r1,r1,1 -> wb_out 0x7FFF then 0x8000; SUBI r2,r0,1 -> 0xFFFF.

Source files
------------

// File: rtl/rv32i_pipe_param.sv
// rv32i_pipe_param: parametrised 5-stage in-order pipeline (IF, ID, EX, MEM, WB)
// for the 6-bit-opcode custom ISA.
//
// Configuration macro: RV_PIPE_FORWARD_EN
//   defined   -> EX/MEM and MEM/WB forwarding into EX, only load-use stalls
//   undefined -> no forwarding; ID stalls while EX or MEM will write a source
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   imem_addr  instruction fetch address (word address, equals pc)
//   imem_data  instruction word at imem_addr, combinational
//   pc         current fetch pc
//   wb_out     value most recently written to the register file
//   wb_valid   one-cycle pulse when wb_out carries a new register write
//   halted     sticky, set once HALT retires
module rv32i_pipe_param #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_AW    = 10,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [IMEM_AW-1:0] pc,
  output logic [XLEN-1:0]    wb_out,
  output logic               wb_valid,
  output logic               halted
);
  localparam int RW  = $clog2(NREG);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_MUL = 6'd2,  OP_DIV = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4, OP_SUBI = 6'd5, OP_LOAD = 6'd6, OP_STORE = 6'd7;
  localparam logic [5:0] OP_BEQ = 6'd8,  OP_AND = 6'd9,  OP_OR = 6'd10,  OP_BNE = 6'd11;
  localparam logic [5:0] OP_HALT = 6'd63;

  // fetch / IF-ID
  logic [IMEM_AW-1:0] r_pc, r_ifid_pc;
  logic               r_fetch_stop, r_ifid_valid;
  logic [31:0]        r_ifid_instr;
  // ID-EX
  logic               r_idex_valid, r_idex_wen;
  logic [5:0]         r_idex_op;
  logic [RW-1:0]      r_idex_dest;
  logic [XLEN-1:0]    r_idex_a, r_idex_b, r_idex_imm;
  logic [IMEM_AW-1:0] r_idex_pc;
`ifdef RV_PIPE_FORWARD_EN
  logic [RW-1:0]      r_idex_rs, r_idex_rt;
`endif
  // EX-MEM
  logic               r_exmem_valid, r_exmem_wen, r_exmem_load, r_exmem_store, r_exmem_halt;
  logic [RW-1:0]      r_exmem_dest;
  logic [XLEN-1:0]    r_exmem_result, r_exmem_sdata;
  // MEM-WB
  logic               r_memwb_valid, r_memwb_wen, r_memwb_load, r_memwb_halt;
  logic [RW-1:0]      r_memwb_dest;
  logic [XLEN-1:0]    r_memwb_result;
  // state
  logic [XLEN-1:0]    r_rf [NREG];
  logic [XLEN-1:0]    r_dmem [DMEM_DEPTH];
  logic [XLEN-1:0]    r_dmem_rdata, r_wb_out;
  logic               r_wb_valid, r_halted;

  // ---------------- ID decode ----------------
  logic [5:0]      w_op;
  logic [RW-1:0]   w_rs, w_rt, w_rd, w_dest;
  logic [XLEN-1:0] w_imm, w_rs_val, w_rt_val, w_wb_data;
  logic            w_rtype, w_itype, w_wen, w_use_rs, w_use_rt, w_id_halt, w_wb_we, w_stall;

  assign w_op      = r_ifid_instr[31:26];
  assign w_rs      = r_ifid_instr[21 +: RW];
  assign w_rt      = r_ifid_instr[16 +: RW];
  assign w_rd      = r_ifid_instr[11 +: RW];
  assign w_imm     = XLEN'($signed(r_ifid_instr[15:0]));
  assign w_rtype   = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_MUL) ||
                     (w_op == OP_DIV) || (w_op == OP_AND) || (w_op == OP_OR);
  assign w_itype   = (w_op == OP_ADDI) || (w_op == OP_SUBI) || (w_op == OP_LOAD);
  assign w_dest    = w_rtype ? w_rd : w_rt;
  // Writes to register 0 are dropped at decode so no later stage ever matches it.
  assign w_wen     = (w_rtype || w_itype) && (w_dest != '0);
  assign w_use_rt  = w_rtype || (w_op == OP_STORE) || (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_use_rs  = w_use_rt || w_itype;
  assign w_id_halt = r_ifid_valid && (w_op == OP_HALT);

  assign w_wb_we   = r_memwb_valid && r_memwb_wen;
  assign w_wb_data = r_memwb_load ? r_dmem_rdata : r_memwb_result;

  // Write-through read: the instruction in WB is visible to ID this cycle.
  assign w_rs_val = (w_rs == '0) ? '0 : (w_wb_we && r_memwb_dest == w_rs) ? w_wb_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : (w_wb_we && r_memwb_dest == w_rt) ? w_wb_data : r_rf[w_rt];

  // ---------------- hazards and EX operands ----------------
  logic [XLEN-1:0] w_ex_a, w_ex_b;
`ifdef RV_PIPE_FORWARD_EN
  logic w_fa_mem, w_fb_mem, w_fa_wb, w_fb_wb;
  assign w_fa_mem = r_exmem_valid && r_exmem_wen && (r_exmem_dest == r_idex_rs);
  assign w_fb_mem = r_exmem_valid && r_exmem_wen && (r_exmem_dest == r_idex_rt);
  assign w_fa_wb  = w_wb_we && (r_memwb_dest == r_idex_rs);
  assign w_fb_wb  = w_wb_we && (r_memwb_dest == r_idex_rt);
  assign w_ex_a   = w_fa_mem ? r_exmem_result : w_fa_wb ? w_wb_data : r_idex_a;
  assign w_ex_b   = w_fb_mem ? r_exmem_result : w_fb_wb ? w_wb_data : r_idex_b;
  // Only a load result is too late for forwarding.
  assign w_stall  = r_ifid_valid && r_idex_valid && r_idex_wen && (r_idex_op == OP_LOAD) &&
                    ((w_use_rs && r_idex_dest == w_rs) || (w_use_rt && r_idex_dest == w_rt));
`else
  assign w_ex_a   = r_idex_a;
  assign w_ex_b   = r_idex_b;
  // Wait until the producer reaches WB, where the write-through read picks it up.
  assign w_stall  = r_ifid_valid &&
                    ((r_idex_valid && r_idex_wen &&
                      ((w_use_rs && r_idex_dest == w_rs) || (w_use_rt && r_idex_dest == w_rt))) ||
                     (r_exmem_valid && r_exmem_wen &&
                      ((w_use_rs && r_exmem_dest == w_rs) || (w_use_rt && r_exmem_dest == w_rt))));
`endif

  // ---------------- EX ----------------
  logic [XLEN-1:0]    w_alu;
  logic               w_flush;
  logic [IMEM_AW-1:0] w_br_target;

  always_comb begin
    w_alu = '0;
    case (r_idex_op)
      OP_ADD:                    w_alu = w_ex_a + w_ex_b;
      OP_SUB:                    w_alu = w_ex_a - w_ex_b;
      OP_MUL:                    w_alu = w_ex_a * w_ex_b;
      OP_DIV:                    w_alu = (w_ex_b == '0) ? '1 : (w_ex_a / w_ex_b);
      OP_ADDI, OP_LOAD, OP_STORE: w_alu = w_ex_a + r_idex_imm;
      OP_SUBI:                   w_alu = w_ex_a - r_idex_imm;
      OP_AND:                    w_alu = w_ex_a & w_ex_b;
      OP_OR:                     w_alu = w_ex_a | w_ex_b;
      default:                   w_alu = '0;
    endcase
  end

  assign w_flush     = r_idex_valid && (((r_idex_op == OP_BEQ) && (w_ex_a == w_ex_b)) ||
                                        ((r_idex_op == OP_BNE) && (w_ex_a != w_ex_b)));
  assign w_br_target = r_idex_pc + IMEM_AW'(1) + r_idex_imm[IMEM_AW-1:0];

  // ---------------- MEM ----------------
  logic [DAW-1:0] w_dmem_addr;
  assign w_dmem_addr = DAW'(r_exmem_result % XLEN'(DMEM_DEPTH));

  always_ff @(posedge clk) begin
    if (r_exmem_valid && r_exmem_store) r_dmem[w_dmem_addr] <= r_exmem_sdata;
    r_dmem_rdata <= r_dmem[w_dmem_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wb_we) begin
      r_rf[r_memwb_dest] <= w_wb_data;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0; r_fetch_stop <= 1'b0;
      r_ifid_valid <= 1'b0; r_ifid_instr <= '0; r_ifid_pc <= '0;
      r_idex_valid <= 1'b0; r_idex_wen <= 1'b0; r_idex_op <= '0; r_idex_dest <= '0;
      r_idex_a <= '0; r_idex_b <= '0; r_idex_imm <= '0; r_idex_pc <= '0;
`ifdef RV_PIPE_FORWARD_EN
      r_idex_rs <= '0; r_idex_rt <= '0;
`endif
      r_exmem_valid <= 1'b0; r_exmem_wen <= 1'b0; r_exmem_load <= 1'b0; r_exmem_store <= 1'b0;
      r_exmem_halt <= 1'b0; r_exmem_dest <= '0; r_exmem_result <= '0; r_exmem_sdata <= '0;
      r_memwb_valid <= 1'b0; r_memwb_wen <= 1'b0; r_memwb_load <= 1'b0; r_memwb_halt <= 1'b0;
      r_memwb_dest <= '0; r_memwb_result <= '0;
      r_wb_out <= '0; r_wb_valid <= 1'b0; r_halted <= 1'b0;
    end else begin
      // IF: a taken branch beats a stall; HALT in ID stops fetching for good.
      if (w_flush) begin
        r_pc         <= w_br_target;
        r_ifid_valid <= 1'b0;
      end else if (w_stall) begin
        r_pc         <= r_pc;
      end else if (w_id_halt || r_fetch_stop) begin
        r_ifid_valid <= 1'b0;
      end else begin
        r_pc         <= r_pc + IMEM_AW'(1);
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= imem_data;
        r_ifid_pc    <= r_pc;
      end
      if (w_id_halt && !w_flush) r_fetch_stop <= 1'b1;

      // ID -> EX
      r_idex_valid <= r_ifid_valid && !w_flush && !w_stall;
      r_idex_wen   <= w_wen;
      r_idex_op    <= w_op;
      r_idex_dest  <= w_dest;
      r_idex_a     <= w_rs_val;
      r_idex_b     <= w_rt_val;
      r_idex_imm   <= w_imm;
      r_idex_pc    <= r_ifid_pc;
`ifdef RV_PIPE_FORWARD_EN
      r_idex_rs    <= w_rs;
      r_idex_rt    <= w_rt;
`endif

      // EX -> MEM
      r_exmem_valid  <= r_idex_valid;
      r_exmem_wen    <= r_idex_wen;
      r_exmem_load   <= (r_idex_op == OP_LOAD);
      r_exmem_store  <= (r_idex_op == OP_STORE);
      r_exmem_halt   <= (r_idex_op == OP_HALT);
      r_exmem_dest   <= r_idex_dest;
      r_exmem_result <= w_alu;
      r_exmem_sdata  <= w_ex_b;

      // MEM -> WB
      r_memwb_valid  <= r_exmem_valid;
      r_memwb_wen    <= r_exmem_wen;
      r_memwb_load   <= r_exmem_load;
      r_memwb_halt   <= r_exmem_halt;
      r_memwb_dest   <= r_exmem_dest;
      r_memwb_result <= r_exmem_result;

      // WB reporting
      r_wb_valid <= w_wb_we;
      if (w_wb_we) r_wb_out <= w_wb_data;
      if (r_memwb_valid && r_memwb_halt) r_halted <= 1'b1;
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign wb_out    = r_wb_out;
  assign wb_valid  = r_wb_valid;
  assign halted    = r_halted;
endmodule

// File: tb/tb_rv32i_pipe_param.sv
module tb_rv32i_pipe_param;
  localparam int AW = 10;
  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_MUL = 6'd2, OP_DIV = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4, OP_SUBI = 6'd5, OP_LOAD = 6'd6, OP_STORE = 6'd7;
  localparam logic [5:0] OP_BEQ = 6'd8, OP_AND = 6'd9, OP_OR = 6'd10, OP_BNE = 6'd11;
  localparam logic [5:0] OP_HALT = 6'd63;
  localparam logic [31:0] NOP = 32'h3000_0000;
`ifdef RV_PIPE_FORWARD_EN
  localparam int GAP_ADD = 1, GAP_SL = 2, GAP_LU = 2;
`else
  localparam int GAP_ADD = 3, GAP_SL = 4, GAP_LU = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] imem_addr, pc, imem_addr16, pc16;
  logic [31:0]   imem_data, imem_data16, wb_out;
  logic [15:0]   wb_out16;
  logic          wb_valid, halted, wb_valid16, halted16;
  logic [31:0]   imem32 [1024];
  logic [31:0]   imem16 [1024];

  assign imem_data   = imem32[imem_addr];
  assign imem_data16 = imem16[imem_addr16];

  rv32i_pipe_param dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .wb_out(wb_out), .wb_valid(wb_valid), .halted(halted)
  );

  rv32i_pipe_param #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr16), .imem_data(imem_data16), .pc(pc16),
    .wb_out(wb_out16), .wb_valid(wb_valid16), .halted(halted16)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  longint      cycle = 0;
  longint      rel_cyc = 0;
  int          idx32 = 0, idx16 = 0, base32 = 0;
  longint      cyc32 [128];
  logic [31:0] q32 [$];
  logic [31:0] q16 [$];
  logic [31:0] exp32 [14] = '{32'd5, 32'd7, 32'd12, 32'd12, 32'd24, 32'd1, 32'd2,
                              32'hFFFF_FFFF, 32'd0, 32'd2, 32'd35, 32'd5, 32'd13, 32'hFFFF_FFFF};
  logic [31:0] exp16 [3]  = '{32'h7FFF, 32'h8000, 32'hFFFF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard consumers: one line per retired register write.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (q32.size() == 0) check("wb32_extra", {31'b0, wb_valid}, 32'd0);
      else check($sformatf("wb32_%0d", idx32), wb_out, q32.pop_front());
      $display("wb32 #%0d value %h cycle %0d", idx32, wb_out, cycle - rel_cyc);
      if (idx32 < 128) cyc32[idx32] = cycle - rel_cyc;
      idx32++;
    end
  end

  always @(negedge clk) begin
    if (!rst && wb_valid16) begin
      if (q16.size() == 0) check("wb16_extra", {31'b0, wb_valid16}, 32'd0);
      else check($sformatf("wb16_%0d", idx16), {16'd0, wb_out16}, q16.pop_front());
      $display("wb16 #%0d value %h cycle %0d", idx16, wb_out16, cycle - rel_cyc);
      idx16++;
    end
  end

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cycle;
    base32 = idx32;
    foreach (exp32[i]) q32.push_back(exp32[i]);
    foreach (exp16[i]) q16.push_back(exp16[i]);
  endtask

  initial begin
    int     changed;
    logic [AW-1:0] p;
    foreach (imem32[i]) begin imem32[i] = NOP; imem16[i] = NOP; end
    foreach (cyc32[i]) cyc32[i] = -1;
    imem32[0]  = enc_i(OP_ADDI, 1, 0, 16'd5);
    imem32[1]  = enc_i(OP_ADDI, 2, 0, 16'd7);
    imem32[2]  = enc_r(OP_ADD, 3, 1, 2);
    imem32[3]  = enc_i(OP_STORE, 3, 0, 16'd4);
    imem32[4]  = enc_i(OP_LOAD, 4, 0, 16'd4);
    imem32[5]  = enc_r(OP_ADD, 5, 4, 4);
    imem32[6]  = enc_i(OP_BEQ, 1, 1, 16'd2);
    imem32[7]  = enc_i(OP_ADDI, 6, 0, 16'd1);
    imem32[8]  = enc_i(OP_ADDI, 7, 0, 16'd2);
    imem32[9]  = enc_i(OP_BNE, 1, 1, 16'd2);
    imem32[10] = enc_i(OP_ADDI, 6, 0, 16'd1);
    imem32[11] = enc_i(OP_ADDI, 7, 0, 16'd2);
    imem32[12] = enc_r(OP_DIV, 8, 1, 0);
    imem32[13] = enc_i(OP_ADDI, 0, 0, 16'd9);
    imem32[14] = enc_r(OP_ADD, 9, 0, 0);
    imem32[15] = enc_r(OP_SUB, 10, 2, 1);
    imem32[16] = enc_r(OP_MUL, 11, 1, 2);
    imem32[17] = enc_r(OP_AND, 12, 1, 2);
    imem32[18] = enc_r(OP_OR, 13, 1, 3);
    imem32[19] = enc_i(OP_SUBI, 14, 0, 16'd1);
    imem32[20] = {OP_HALT, 26'd0};
    imem32[21] = enc_i(OP_ADDI, 15, 0, 16'd3);
    imem16[0]  = enc_i(OP_ADDI, 1, 0, 16'h7FFF);
    imem16[1]  = enc_i(OP_ADDI, 1, 1, 16'd1);
    imem16[2]  = enc_i(OP_SUBI, 2, 0, 16'd1);
    imem16[3]  = {OP_HALT, 26'd0};

    #1 rst = 1'b1;
    #1;
    check("rst_pc", {22'd0, pc}, 32'd0);
    check("rst_wb_out", wb_out, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_pc16", {22'd0, pc16}, 32'd0);

    // Run 1: interrupted by an asynchronous reset mid-stream.
    repeat (2) @(posedge clk);
    release_rst();
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_wb_out", wb_out, 32'd0);
    check("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("arst_pc", {22'd0, pc}, 32'd0);
    check("arst_halted16", {31'b0, halted16}, 32'd0);
    check("arst_pc16", {22'd0, pc16}, 32'd0);
    check("run1_latency", 32'(cyc32[0]), 32'd5);
    q32.delete();
    q16.delete();
    @(posedge clk);

    // Run 2: full program to HALT.
    release_rst();
    for (int i = 0; i < 400 && !(halted && halted16); i++) @(negedge clk);
    check("halted32", {31'b0, halted}, 32'd1);
    check("halted16", {31'b0, halted16}, 32'd1);
    check("run2_latency", 32'(cyc32[base32]), 32'd5);
    check("gap_addi", 32'(cyc32[base32+1] - cyc32[base32]), 32'd1);
    check("gap_add", 32'(cyc32[base32+2] - cyc32[base32+1]), 32'(GAP_ADD));
    check("gap_store_load", 32'(cyc32[base32+3] - cyc32[base32+2]), 32'(GAP_SL));
    check("gap_load_use", 32'(cyc32[base32+4] - cyc32[base32+3]), 32'(GAP_LU));

    p = pc;
    changed = 0;
    repeat (20) begin
      @(negedge clk);
      if (pc != p) changed++;
    end
    check("halt_pc", {22'd0, pc}, 32'd21);
    check("halt_pc_frozen", 32'(changed), 32'd0);
    check("halt_pc16", {22'd0, pc16}, 32'd4);
    check("halted_sticky", {31'b0, halted}, 32'd1);
    check("q32_drained", 32'(q32.size()), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
